burst_ram: RTL and testbench



---
 rtl/burst_ram_if.sv | 33 +++
 rtl/burst_ram.sv | 141 ++++++++++++++
 tb/tb_burst_ram.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_ram_if.sv
// burst_ram_if: command/data bus of the burst RAM.
//   cmd           0 = read burst, 1 = write burst
//   cmd_en        command strobe
//   addr          first word address of the burst
//   wr_data       write word (first word goes with cmd_en)
//   data_mask     per-byte mask, bit i = 1 keeps byte i unchanged
//   rd_data       read word, zero when rd_data_valid is low
//   rd_data_valid rd_data carries a burst word this cycle
//   busy          commands are not accepted while high
// Modports: master drives commands, slave is the RAM.
interface burst_ram_if #(
    parameter int unsigned DEPTH_BITWIDTH = 4,
    parameter int unsigned DATA_BITWIDTH  = 64
);
    logic                         cmd;
    logic                         cmd_en;
    logic [DEPTH_BITWIDTH-1:0]    addr;
    logic [DATA_BITWIDTH-1:0]     wr_data;
    logic [DATA_BITWIDTH/8-1:0]   data_mask;
    logic [DATA_BITWIDTH-1:0]     rd_data;
    logic                         rd_data_valid;
    logic                         busy;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, busy
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, busy
    );
endinterface

// File: rtl/burst_ram.sv
// burst_ram: single-port word RAM accessed in fixed-length bursts.
// After reset release the block stays busy for CYCLES_BEFORE_INITIATED cycles,
// then accepts one read or write burst at a time while idle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (memory contents survive it)
//   bus    burst_ram_if slave modport (command, write data, read data, busy)
module burst_ram #(
    parameter int unsigned DEPTH_BITWIDTH           = 4,
    parameter int unsigned DATA_BITWIDTH            = 64,
    parameter int unsigned BURST_COUNT              = 4,
    parameter int unsigned CYCLES_BEFORE_DATA_VALID = 6,
    parameter int unsigned CYCLES_BEFORE_INITIATED  = 10
) (
    input logic           clk,
    input logic           rst_n,
    burst_ram_if.slave    bus
);

    localparam int unsigned Words = 1 << DEPTH_BITWIDTH;
    localparam int unsigned Bytes = DATA_BITWIDTH / 8;
    localparam int unsigned MaxA  = (CYCLES_BEFORE_INITIATED > CYCLES_BEFORE_DATA_VALID) ?
                                    CYCLES_BEFORE_INITIATED : CYCLES_BEFORE_DATA_VALID;
    localparam int unsigned MaxCount = (MaxA > BURST_COUNT) ? MaxA : BURST_COUNT;
    localparam int unsigned CntW  = $clog2(MaxCount + 1);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StReadWait,
        StReadBurst,
        StWriteBurst
    } state_e;

    state_e                     state_q, state_d;
    // Shared counter: init cycles, read wait cycles, or beat index within a burst.
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [DEPTH_BITWIDTH-1:0]  addr_q, addr_d;

    logic [DATA_BITWIDTH-1:0]   mem [Words];

    logic                       we;
    logic [DEPTH_BITWIDTH-1:0]  waddr;
    logic [DEPTH_BITWIDTH-1:0]  beat_addr;

    // Truncating add gives the modulo-depth wrap for free.
    assign beat_addr = addr_q + DEPTH_BITWIDTH'(cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we      = 1'b0;
        waddr   = beat_addr;
        unique case (state_q)
            StInit: begin
                if (cnt_q == CntW'(CYCLES_BEFORE_INITIATED - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIdle: begin
                if (bus.cmd_en) begin
                    addr_d = bus.addr;
                    cnt_d  = '0;
                    if (bus.cmd) begin
                        // First write word is stored on the accepting edge itself.
                        we      = 1'b1;
                        waddr   = bus.addr;
                        cnt_d   = CntW'(1);
                        state_d = StWriteBurst;
                    end else if (CYCLES_BEFORE_DATA_VALID == 1) begin
                        state_d = StReadBurst;
                    end else begin
                        state_d = StReadWait;
                    end
                end
            end
            StReadWait: begin
                // cnt_q counts edges since acceptance; the next edge is number cnt_q + 1.
                if (cnt_q == CntW'(CYCLES_BEFORE_DATA_VALID - 1)) begin
                    state_d = StReadBurst;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReadBurst: begin
                if (cnt_q == CntW'(BURST_COUNT - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWriteBurst: begin
                we = 1'b1;
                if (cnt_q == CntW'(BURST_COUNT - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < Bytes; i++) begin
                if (!bus.data_mask[i]) begin
                    mem[waddr][8*i +: 8] <= bus.wr_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.busy          = (state_q != StIdle);
    assign bus.rd_data_valid = (state_q == StReadBurst);
    assign bus.rd_data       = (state_q == StReadBurst) ? mem[beat_addr] : '0;

endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram: directed plus randomized bursts checked against an array model of
// the memory. Inputs are driven and outputs sampled on the falling clock edge.
module tb_burst_ram;

    localparam int unsigned DW   = 4;
    localparam int unsigned DATW = 64;
    localparam int unsigned BC   = 4;
    localparam int unsigned LAT  = 6;
    localparam int unsigned INIT = 10;
    localparam int unsigned NW   = 1 << DW;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    burst_ram_if #(.DEPTH_BITWIDTH(DW), .DATA_BITWIDTH(DATW)) bus ();

    burst_ram #(
        .DEPTH_BITWIDTH          (DW),
        .DATA_BITWIDTH           (DATW),
        .BURST_COUNT             (BC),
        .CYCLES_BEFORE_DATA_VALID(LAT),
        .CYCLES_BEFORE_INITIATED (INIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATW-1:0] model [NW];
    bit              known [NW];
    logic [DATW-1:0] wd [BC];
    logic [7:0]      wm [BC];
    logic [DATW-1:0] exp_rd [BC];
    bit              exp_known [BC];

    task automatic check(input string tag, input logic [DATW-1:0] obs,
                         input logic [DATW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Byte i of old survives where mask bit i is set.
    function automatic logic [DATW-1:0] merge(input logic [DATW-1:0] old,
                                              input logic [DATW-1:0] data,
                                              input logic [7:0] mask);
        logic [DATW-1:0] r;
        r = old;
        for (int i = 0; i < DATW / 8; i++) begin
            if (!mask[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

    task automatic model_write(input logic [DW-1:0] a, input logic [DATW-1:0] d,
                               input logic [7:0] m);
        if (known[a]) begin
            model[a] = merge(model[a], d, m);
        end else if (m == 8'h00) begin
            model[a] = d;
            known[a] = 1'b1;
        end
    endtask

    task automatic set_exp_from_model(input logic [DW-1:0] a);
        for (int k = 0; k < BC; k++) begin
            logic [DW-1:0] ra;
            ra           = a + DW'(k);
            exp_rd[k]    = model[ra];
            exp_known[k] = known[ra];
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_fail++;
            $error("FAIL idle_timeout: observed busy %b expected 0", bus.busy);
        end
    endtask

    // Asserts reset just after a falling edge, checks the asynchronous effect,
    // releases it just after a rising edge and measures the init busy window.
    task automatic do_reset();
        int cnt;
        bus.cmd_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd1);
        check("rst_valid", 64'(bus.rd_data_valid), 64'd0);
        check("rst_rd_data", bus.rd_data, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 50) begin
            check("init_valid", 64'(bus.rd_data_valid), 64'd0);
            cnt++;
            @(negedge clk);
        end
        check("init_busy_cycles", 64'(cnt), 64'(INIT));
    endtask

    // abort_after < BC: reset once that many words have been written.
    task automatic do_write(input logic [DW-1:0] a, input int abort_after);
        wait_idle();
        bus.cmd       = 1'b1;
        bus.cmd_en    = 1'b1;
        bus.addr      = a;
        bus.wr_data   = wd[0];
        bus.data_mask = wm[0];
        for (int k = 1; k < BC; k++) begin
            @(negedge clk);
            model_write(a + DW'(k - 1), wd[k - 1], wm[k - 1]);
            check("wr_busy", 64'(bus.busy), 64'd1);
            if (k == abort_after) begin
                do_reset();
                return;
            end
            bus.wr_data   = wd[k];
            bus.data_mask = wm[k];
            bus.cmd_en    = 1'($urandom);
            bus.cmd       = 1'($urandom);
            bus.addr      = DW'($urandom);
        end
        @(negedge clk);
        model_write(a + DW'(BC - 1), wd[BC - 1], wm[BC - 1]);
        bus.cmd_en = 1'b0;
        check("wr_busy_release", 64'(bus.busy), 64'd0);
    endtask

    // noisy: random command traffic while busy; abort_after < BC: reset after
    // that many read words have been seen.
    task automatic do_read(input logic [DW-1:0] a, input bit noisy, input int abort_after);
        wait_idle();
        bus.cmd    = 1'b0;
        bus.cmd_en = 1'b1;
        bus.addr   = a;
        @(negedge clk);
        for (int j = 0; j < LAT; j++) begin
            bus.cmd_en    = noisy ? 1'($urandom) : 1'b0;
            bus.cmd       = 1'($urandom);
            bus.addr      = DW'($urandom);
            bus.wr_data   = {$urandom, $urandom};
            bus.data_mask = 8'($urandom);
            check("rd_wait_valid", 64'(bus.rd_data_valid), 64'd0);
            check("rd_wait_data", bus.rd_data, '0);
            check("rd_wait_busy", 64'(bus.busy), 64'd1);
            @(negedge clk);
        end
        for (int k = 0; k < BC; k++) begin
            bus.cmd_en = (noisy && k < BC - 1) ? 1'($urandom) : 1'b0;
            check("rd_valid", 64'(bus.rd_data_valid), 64'd1);
            check("rd_busy", 64'(bus.busy), 64'd1);
            if (exp_known[k]) check("rd_data", bus.rd_data, exp_rd[k]);
            if (k + 1 == abort_after) begin
                do_reset();
                return;
            end
            @(negedge clk);
        end
        check("rd_end_valid", 64'(bus.rd_data_valid), 64'd0);
        check("rd_end_data", bus.rd_data, '0);
        check("rd_end_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.cmd       = 1'b0;
        bus.cmd_en    = 1'b0;
        bus.addr      = '0;
        bus.wr_data   = '0;
        bus.data_mask = '0;
        for (int i = 0; i < NW; i++) begin
            model[i] = '0;
            known[i] = 1'b0;
        end
        #2;
        do_reset();

        // Plain burst write then read back.
        wd[0] = {8{8'h11}}; wd[1] = {8{8'h22}}; wd[2] = {8{8'h33}}; wd[3] = {8{8'h44}};
        for (int k = 0; k < BC; k++) wm[k] = 8'h00;
        do_write(4'd4, BC);
        exp_rd[0] = 64'h1111_1111_1111_1111; exp_rd[1] = 64'h2222_2222_2222_2222;
        exp_rd[2] = 64'h3333_3333_3333_3333; exp_rd[3] = 64'h4444_4444_4444_4444;
        for (int k = 0; k < BC; k++) exp_known[k] = 1'b1;
        do_read(4'd4, 1'b0, BC);

        // Byte mask keeps the low half of an all-ones word.
        for (int k = 0; k < BC; k++) begin
            wd[k] = '1;
            wm[k] = 8'h00;
        end
        do_write(4'd8, BC);
        wd[0] = '0; wm[0] = 8'h0F;
        for (int k = 1; k < BC; k++) begin
            wd[k] = '0;
            wm[k] = 8'hFF;
        end
        do_write(4'd8, BC);
        exp_rd[0] = 64'h0000_0000_FFFF_FFFF;
        for (int k = 1; k < BC; k++) exp_rd[k] = '1;
        do_read(4'd8, 1'b0, BC);

        // Address wrap across the top of memory.
        wd[0] = 64'hE; wd[1] = 64'hF; wd[2] = 64'h0; wd[3] = 64'h1;
        for (int k = 0; k < BC; k++) wm[k] = 8'h00;
        do_write(4'd14, BC);
        exp_rd[0] = 64'hE; exp_rd[1] = 64'hF; exp_rd[2] = 64'h0; exp_rd[3] = 64'h1;
        do_read(4'd14, 1'b0, BC);

        // Command strobes during a read are ignored; memory must be unchanged.
        set_exp_from_model(4'd4);
        do_read(4'd4, 1'b1, BC);
        set_exp_from_model(4'd4);
        do_read(4'd4, 1'b0, BC);

        // Reset between read words 2 and 3.
        set_exp_from_model(4'd4);
        do_read(4'd4, 1'b0, 2);

        // Reset after two words of a write burst: only those two land.
        for (int k = 0; k < BC; k++) begin
            wd[k] = {$urandom, $urandom};
            wm[k] = 8'h00;
        end
        do_write(4'd4, 2);
        set_exp_from_model(4'd4);
        do_read(4'd4, 1'b0, BC);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            logic [DW-1:0] a;
            a = DW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < BC; k++) begin
                    wd[k] = {$urandom, $urandom};
                    wm[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
                end
                do_write(a, BC);
            end else begin
                set_exp_from_model(a);
                do_read(a, 1'($urandom), BC);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
